// File: rtl/stateful_alu_v2.sv
// stateful_alu_v2: one-slot RMT stateful ALU with a tenant-paged private state RAM.
// Latency 3 cycles accept-to-result; one action in flight, ready_out low until ready_in handshake.
// STATEFUL_ALU_SAT_EN: clamp arithmetic (unsigned saturate) instead of wrapping.
module stateful_alu_v2 #(
    parameter int STAGE_ID   = 0,
    parameter int ACTION_LEN = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ACTION_LEN-1:0]   action_in,
    input  logic                    action_valid,
    input  logic [DATA_WIDTH-1:0]   operand_1_in,
    input  logic [DATA_WIDTH-1:0]   operand_2_in,
    input  logic [DATA_WIDTH-1:0]   operand_3_in,
    output logic                    ready_out,
    input  logic [2*ADDR_WIDTH-1:0] page_tbl_out,
    input  logic                    page_tbl_out_valid,
    output logic [DATA_WIDTH-1:0]   container_out,
    output logic                    container_out_valid,
    output logic                    overflow_out,
    input  logic                    ready_in
);
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_ADDI  = 8'h09;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_SUBI  = 8'h0A;
    localparam logic [7:0] OP_SET   = 8'h0E;
    localparam logic [7:0] OP_LOAD  = 8'h0B;
    localparam logic [7:0] OP_STORE = 8'h08;
    localparam logic [7:0] OP_LOADD = 8'h07;
    localparam logic [7:0] OP_FADD  = 8'h0F;

    typedef enum logic [1:0] {IDLE, RD, EXEC, OUT} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    logic [7:0]            opc_q;
    logic [DATA_WIDTH-1:0] op1_q, op2_q, op3_q, rd_q, wr_dat_q;
    logic [ADDR_WIDTH-1:0] phys_q;
    logic                  wr_pend_q;

    logic                  accept, wr_en, ram_op_in, ovf_in;
    logic [7:0]            opc_in;
    logic [ADDR_WIDTH-1:0] offset_in, base_in, len_in, phys_in;
    logic unused_bits;

    assign opc_in    = action_in[ACTION_LEN-1 -: 8];
    assign offset_in = operand_2_in[ADDR_WIDTH-1:0];
    assign base_in   = page_tbl_out[ADDR_WIDTH-1:0];
    assign len_in    = page_tbl_out[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign phys_in   = base_in + offset_in;
    assign accept    = action_valid && ready_out;
    assign ram_op_in = (opc_in == OP_LOAD) || (opc_in == OP_STORE) ||
                       (opc_in == OP_LOADD) || (opc_in == OP_FADD);
    assign ovf_in    = ram_op_in && (!page_tbl_out_valid || (offset_in > len_in));
    // A reset in the handshake cycle must still drop the pending write.
    assign wr_en     = (state == OUT) && ready_in && wr_pend_q && !rst;
    assign unused_bits = ^{action_in[ACTION_LEN-9:0], operand_2_in[DATA_WIDTH-1:ADDR_WIDTH], STAGE_ID[0]};

    logic [DATA_WIDTH-1:0] add_v, sub_v, inc_v, fa_v;
`ifdef STATEFUL_ALU_SAT_EN
    logic [DATA_WIDTH:0] sum_ab, sum_inc, sum_fa;
    assign sum_ab  = {1'b0, op1_q} + {1'b0, op2_q};
    assign sum_inc = {1'b0, rd_q} + (DATA_WIDTH+1)'(1);
    assign sum_fa  = {1'b0, rd_q} + {1'b0, op1_q};
    assign add_v   = sum_ab[DATA_WIDTH]  ? {DATA_WIDTH{1'b1}} : sum_ab[DATA_WIDTH-1:0];
    assign inc_v   = sum_inc[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_inc[DATA_WIDTH-1:0];
    assign fa_v    = sum_fa[DATA_WIDTH]  ? {DATA_WIDTH{1'b1}} : sum_fa[DATA_WIDTH-1:0];
    assign sub_v   = (op1_q < op2_q) ? '0 : op1_q - op2_q;
`else
    assign add_v = op1_q + op2_q;
    assign inc_v = rd_q + DATA_WIDTH'(1);
    assign fa_v  = rd_q + op1_q;
    assign sub_v = op1_q - op2_q;
`endif

    logic [DATA_WIDTH-1:0] exec_res, exec_wdat;
    logic                  exec_wr;

    always_comb begin
        exec_res  = op3_q;
        exec_wdat = '0;
        exec_wr   = 1'b0;
        case (opc_q)
            OP_ADD, OP_ADDI: exec_res = add_v;
            OP_SUB, OP_SUBI: exec_res = sub_v;
            OP_SET:          exec_res = op2_q;
            OP_LOAD:  if (!overflow_out) exec_res = rd_q;
            OP_STORE: if (!overflow_out) begin
                exec_wr   = 1'b1;
                exec_wdat = op1_q;
            end
            OP_LOADD: if (!overflow_out) begin
                exec_res  = inc_v;
                exec_wr   = 1'b1;
                exec_wdat = inc_v;
            end
            OP_FADD: if (!overflow_out) begin
                exec_res  = rd_q;
                exec_wr   = 1'b1;
                exec_wdat = fa_v;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RD;
            RD:      state_nxt = EXEC;
            EXEC:    state_nxt = OUT;
            OUT:     if (ready_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State RAM: no reset; read-during-write to the same address forwards the new data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[phys_q] <= wr_dat_q;
        if (accept) rd_q <= (wr_en && (phys_q == phys_in)) ? wr_dat_q : mem[phys_in];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            ready_out           <= 1'b1;
            container_out       <= '0;
            container_out_valid <= 1'b0;
            overflow_out        <= 1'b0;
            wr_pend_q           <= 1'b0;
            wr_dat_q            <= '0;
            opc_q               <= '0;
            op1_q               <= '0;
            op2_q               <= '0;
            op3_q               <= '0;
            phys_q              <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opc_q        <= opc_in;
                op1_q        <= operand_1_in;
                op2_q        <= operand_2_in;
                op3_q        <= operand_3_in;
                phys_q       <= phys_in;
                overflow_out <= ovf_in;
                ready_out    <= 1'b0;
            end
            if (state == EXEC) begin
                container_out       <= exec_res;
                container_out_valid <= 1'b1;
                wr_pend_q           <= exec_wr;
                wr_dat_q            <= exec_wdat;
            end
            if ((state == OUT) && ready_in) begin
                container_out_valid <= 1'b0;
                ready_out           <= 1'b1;
                wr_pend_q           <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stateful_alu_v2.sv
// Bench for stateful_alu_v2: directed vector table, reset corner sequences, random actions vs. a reference model.
module tb_stateful_alu_v2;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] action_in;
    logic        action_valid;
    logic [31:0] operand_1_in, operand_2_in, operand_3_in;
    logic        ready_out;
    logic [9:0]  page_tbl_out;
    logic        page_tbl_out_valid;
    logic [31:0] container_out;
    logic        container_out_valid;
    logic        overflow_out;
    logic        ready_in;

    always #5 clk = ~clk;

    stateful_alu_v2 #(.STAGE_ID(0), .ACTION_LEN(64), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .action_in(action_in), .action_valid(action_valid),
        .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
        .ready_out(ready_out), .page_tbl_out(page_tbl_out), .page_tbl_out_valid(page_tbl_out_valid),
        .container_out(container_out), .container_out_valid(container_out_valid),
        .overflow_out(overflow_out), .ready_in(ready_in)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] ram_m [32];
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a, b, c;
        logic [9:0]  pt;
        logic        ptv;
        int          hold;
        logic [31:0] er;
        logic        eo;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] clamp_add(input longint s);
`ifdef STATEFUL_ALU_SAT_EN
        if (s > MAXV) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] clamp_sub(input logic [31:0] x, input logic [31:0] y);
`ifdef STATEFUL_ALU_SAT_EN
        if (x < y) return 32'h0;
`endif
        return x - y;
    endfunction

    // Reference: applies one action to the RAM image and returns expected outputs.
    task automatic model(input logic [7:0] op, input logic [31:0] a, b, c, input logic [9:0] pt,
                         input logic ptv, output logic [31:0] res, output logic ovf);
        int off, len, base, phys;
        bit is_ram;
        off  = int'(b[4:0]);
        len  = int'(pt[9:5]);
        base = int'(pt[4:0]);
        phys = (base + off) % 32;
        is_ram = (op == 8'h0B) || (op == 8'h08) || (op == 8'h07) || (op == 8'h0F);
        ovf = is_ram && (!ptv || off > len);
        res = c;
        case (op)
            8'h01, 8'h09: res = clamp_add(longint'({32'h0, a}) + longint'({32'h0, b}));
            8'h02, 8'h0A: res = clamp_sub(a, b);
            8'h0E:        res = b;
            8'h0B: if (!ovf) res = ram_m[phys];
            8'h08: if (!ovf) ram_m[phys] = a;
            8'h07: if (!ovf) begin
                res = clamp_add(longint'({32'h0, ram_m[phys]}) + 1);
                ram_m[phys] = res;
            end
            8'h0F: if (!ovf) begin
                res = ram_m[phys];
                ram_m[phys] = clamp_add(longint'({32'h0, ram_m[phys]}) + longint'({32'h0, a}));
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, b, c, input logic [9:0] pt, input logic ptv);
        action_in          = {op, 24'h0, 32'($urandom)};
        operand_1_in       = a;
        operand_2_in       = b;
        operand_3_in       = c;
        page_tbl_out       = pt;
        page_tbl_out_valid = ptv;
        action_valid       = 1'b1;
    endtask

    task automatic run(input string name, input logic [7:0] op, input logic [31:0] a, b, c,
                       input logic [9:0] pt, input logic ptv, input int hold, input bit junk,
                       input logic [31:0] er, input logic eo);
        int lat;
        bit got;
        @(negedge clk);
        check({name, ".rdy_idle"}, 64'(ready_out), 64'd1);
        drive(op, a, b, c, pt, ptv);
        ready_in = (hold == 0);
        @(posedge clk);
        #1 action_valid = 1'b0;
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (container_out_valid) got = 1;
            else if (junk) drive(8'h08, $urandom, $urandom, $urandom, 10'h3FF, 1'b1);
        end
        action_valid = 1'b0;
        check({name, ".latency"}, 64'(lat), 64'd3);
        check({name, ".res"}, 64'(container_out), 64'(er));
        check({name, ".ovf"}, 64'(overflow_out), 64'(eo));
        check({name, ".rdy_busy"}, 64'(ready_out), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, ".vld_held"}, 64'(container_out_valid), 64'd1);
            check({name, ".res_held"}, 64'(container_out), 64'(er));
            check({name, ".rdy_held"}, 64'(ready_out), 64'd0);
        end
        ready_in = 1'b1;
        @(negedge clk);
        check({name, ".rdy_back"}, 64'(ready_out), 64'd1);
        check({name, ".vld_drop"}, 64'(container_out_valid), 64'd0);
    endtask

    task automatic rst_mid(input string name, input logic [7:0] op, input logic [31:0] a, b, c,
                           input logic [9:0] pt, input int edges);
        @(negedge clk);
        drive(op, a, b, c, pt, 1'b1);
        ready_in = 1'b0;
        @(posedge clk);
        #1 action_valid = 1'b0;
        repeat (edges) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check({name, ".rdy"}, 64'(ready_out), 64'd1);
        check({name, ".vld"}, 64'(container_out_valid), 64'd0);
        check({name, ".res"}, 64'(container_out), 64'd0);
        check({name, ".ovf"}, 64'(overflow_out), 64'd0);
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] a, b, c, input logic [9:0] pt,
                                input logic ptv, input int hold, input logic [31:0] er, input logic eo);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.pt = pt; v.ptv = ptv;
        v.hold = hold; v.er = er; v.eo = eo;
        return v;
    endfunction

`ifdef STATEFUL_ALU_SAT_EN
    localparam logic [31:0] FA_RAM = 32'hFFFF_FFFF, SUB35 = 32'h0, ADDOV = 32'hFFFF_FFFF, AFTER = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] FA_RAM = 32'h5, SUB35 = 32'hFFFF_FFFE, ADDOV = 32'h1, AFTER = 32'h6;
`endif
    localparam logic [9:0] PT87 = {5'd7, 5'd8};
    localparam logic [9:0] PTF  = {5'd31, 5'd0};
    localparam logic [9:0] PTW  = {5'd15, 5'd30};

    initial begin
        logic [31:0] er;
        logic        eo;
        logic [7:0]  ops [10];
        rst = 1'b1; action_in = '0; action_valid = 1'b0; operand_1_in = '0; operand_2_in = '0;
        operand_3_in = '0; page_tbl_out = '0; page_tbl_out_valid = 1'b0; ready_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.rdy", 64'(ready_out), 64'd1);
        check("reset.vld", 64'(container_out_valid), 64'd0);
        check("reset.res", 64'(container_out), 64'd0);
        check("reset.ovf", 64'(overflow_out), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            model(8'h08, 32'h0, 32'(i), 32'(i + 100), PTF, 1'b1, er, eo);
            run("init", 8'h08, 32'h0, 32'(i), 32'(i + 100), PTF, 1'b1, 0, 0, er, eo);
        end

        tbl.push_back(mk(8'h08, 32'hDEAD, 3, 32'h1234, PT87, 1, 0, 32'h1234, 0));
        tbl.push_back(mk(8'h0B, 0, 3, 0, PT87, 1, 0, 32'hDEAD, 0));
        tbl.push_back(mk(8'h0B, 0, 11, 0, PTF, 1, 0, 32'hDEAD, 0));
        tbl.push_back(mk(8'h08, 5, 0, 32'h77, PT87, 1, 0, 32'h77, 0));
        tbl.push_back(mk(8'h07, 0, 0, 0, PT87, 1, 0, 6, 0));
        tbl.push_back(mk(8'h07, 0, 0, 0, PT87, 1, 0, 7, 0));
        tbl.push_back(mk(8'h07, 0, 0, 0, PT87, 1, 0, 8, 0));
        tbl.push_back(mk(8'h0B, 0, 0, 0, PT87, 1, 0, 8, 0));
        tbl.push_back(mk(8'h0B, 0, 9, 32'hABCD, PT87, 1, 0, 32'hABCD, 1));
        tbl.push_back(mk(8'h01, 2, 3, 0, PT87, 1, 0, 5, 0));
        tbl.push_back(mk(8'h0B, 0, 3, 32'hC0DE, PT87, 0, 0, 32'hC0DE, 1));
        tbl.push_back(mk(8'h09, 7, 8, 0, PT87, 0, 0, 15, 0));
        tbl.push_back(mk(8'h0B, 0, 7, 1, PT87, 1, 0, 0, 0));
        tbl.push_back(mk(8'h08, 32'hFFFF_FFFB, 1, 1, PT87, 1, 0, 1, 0));
        tbl.push_back(mk(8'h0F, 10, 1, 0, PT87, 1, 0, 32'hFFFF_FFFB, 0));
        tbl.push_back(mk(8'h0B, 0, 1, 0, PT87, 1, 0, FA_RAM, 0));
        tbl.push_back(mk(8'h02, 3, 5, 0, PT87, 1, 0, SUB35, 0));
        tbl.push_back(mk(8'h0A, 9, 4, 0, PT87, 1, 0, 5, 0));
        tbl.push_back(mk(8'h0E, 0, 32'h55, 0, PT87, 1, 0, 32'h55, 0));
        tbl.push_back(mk(8'h33, 0, 0, 32'h99, PT87, 0, 0, 32'h99, 0));
        tbl.push_back(mk(8'h0F, 1, 1, 0, PT87, 1, 4, FA_RAM, 0));
        tbl.push_back(mk(8'h0B, 0, 11, 0, PTW, 1, 0, AFTER, 0));
        tbl.push_back(mk(8'h01, 32'hFFFF_FFFF, 2, 0, PT87, 1, 0, ADDOV, 0));
        tbl.push_back(mk(8'h08, 1, 8, 32'h42, PT87, 1, 0, 32'h42, 1));
        tbl.push_back(mk(8'h0B, 0, 16, 0, PTF, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            model(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].pt, tbl[i].ptv, er, eo);
            run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].pt,
                tbl[i].ptv, tbl[i].hold, 0, tbl[i].er, tbl[i].eo);
        end

        rst_mid("rst_exec", 8'h08, 32'h1111, 11, 0, PTF, 1);
        run("after_rst_exec", 8'h0B, 0, 11, 0, PTF, 1'b1, 0, 0, 32'hDEAD, 1'b0);
        rst_mid("rst_out", 8'h0F, 5, 9, 0, PTF, 4);
        run("after_rst_out", 8'h0B, 0, 9, 0, PTF, 1'b1, 0, 0, AFTER, 1'b0);

        ops = '{8'h01, 8'h09, 8'h02, 8'h0A, 8'h0E, 8'h0B, 8'h08, 8'h07, 8'h0F, 8'h00};
        for (int i = 0; i < 200; i++) begin
            logic [7:0]  op;
            logic [31:0] a, b, c;
            logic [9:0]  pt;
            logic        ptv;
            op  = ops[$urandom_range(0, 9)];
            if (op == 8'h00) op = 8'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            b   = $urandom;
            c   = $urandom;
            pt  = 10'($urandom);
            ptv = ($urandom_range(0, 9) != 0);
            model(op, a, b, c, pt, ptv, er, eo);
            run($sformatf("rnd%0d_op%0h", i, op), op, a, b, c, pt, ptv,
                $urandom_range(0, 2), bit'($urandom_range(0, 1)), er, eo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stateful_alu_v2.md
Name: stateful_alu_v2

Overview:
- Parametrised next-generation stateful action ALU for one RMT action-stage container slot.
- Executes one opcode per accepted action on PHV operands.
- Owns a private per-slot state RAM, partitioned between tenants by a page-table base/length pair.
- Adds over the previous generation:
  - parametrised data width and RAM depth;
  - an inferred RAM with in-block write-to-read forwarding;
  - fetch-and-add and saturating-aware arithmetic;
  - a registered overflow indication.

Parameters:
- STAGE_ID, 0, stage index (informational only).
- ACTION_LEN, 64, action word width; opcode is action_in[ACTION_LEN-1 -: 8].
- DATA_WIDTH, 32, container and RAM word width.
- ADDR_WIDTH, 5, RAM address width; depth is 2**ADDR_WIDTH.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- action_in, input, ACTION_LEN, action word.
- action_valid, input, 1, action and operands valid this cycle.
- operand_1_in, input, DATA_WIDTH, first operand (data).
- operand_2_in, input, DATA_WIDTH, second operand (immediate or RAM offset).
- operand_3_in, input, DATA_WIDTH, original container value (passthrough).
- ready_out, output, 1, block can accept an action.
- page_tbl_out, input, 2*ADDR_WIDTH, {addr_len, base_addr}.
- page_tbl_out_valid, input, 1, page table entry valid; sampled with action_valid.
- container_out, output, DATA_WIDTH, result value.
- container_out_valid, output, 1, result strobe.
- overflow_out, output, 1, last action was refused a RAM access.
- ready_in, input, 1, downstream PHV former can take the result.

Behaviour:
- Reset values: ready_out=1, container_out=0, container_out_valid=0, overflow_out=0, state=IDLE. All RAM write enables are 0. RAM contents are not cleared.
- Handshake and latency:
  - An action is accepted when action_valid && ready_out.
  - ready_out falls the next cycle and stays low until the result handshake completes.
  - container_out_valid is a held level, not a single-cycle pulse: it rises in OUT and stays high until the cycle ready_in=1.
  - Minimum latency, accept to container_out_valid high, is 3 cycles.
- State machine: IDLE -> RD -> EXEC -> OUT -> IDLE.
  - IDLE: latch opcode, operands, page entry; issue RAM read; go to RD.
  - RD: RAM read data returns; go to EXEC.
  - EXEC: compute result and write data; go to OUT.
  - OUT: container_out_valid=1. The state advances to IDLE only in the cycle ready_in=1. In that same cycle:
    - the RAM write (if any) commits;
    - ready_out returns to 1 the following cycle.
- Addressing:
  - phys = (base_addr + offset) mod 2**ADDR_WIDTH, where offset = operand_2_in[ADDR_WIDTH-1:0].
  - offset > addr_len, or page_tbl_out_valid=0 at accept: overflow.
    - No RAM write.
    - container_out = operand_3_in.
    - overflow_out = 1.
- Opcodes (arithmetic wraps modulo 2**DATA_WIDTH):
  - 0x01 / 0x09 add: op1+op2.
  - 0x02 / 0x0A sub: op1-op2.
  - 0x0E set: op2.
  - 0x0B load: RAM[phys].
  - 0x08 store: RAM[phys]=op1; output op3.
  - 0x07 loadd: RAM[phys]+1 written back and output.
  - 0x0F fetch-add: output old RAM[phys]; write RAM[phys]+op1.
  - Any other opcode: output op3, no RAM access.
- Non-RAM opcodes: overflow_out=0.
- overflow_out updates at every accept and holds until the next accept.
- Forwarding: RAM read-during-write to the same physical address in one cycle returns the newly written data. Back-to-back loadd actions to the same address must therefore produce +1, +2, ...
- action_valid while ready_out=0: ignored, no side effects.
- rst asserted mid-operation:
  - return to IDLE;
  - any uncommitted write is dropped;
  - outputs return to their reset values next cycle.

Optional Feature:
- Macro: STATEFUL_ALU_SAT_EN.
- Defined: add, addi, loadd and fetch-add clamp at 2**DATA_WIDTH-1; sub and subi clamp at 0 (unsigned).
- Undefined: all arithmetic wraps.

Test Plan:
- Store op1=0xDEAD, offset 3, page {len=7, base=8}; then load offset 3 -> container_out=0xDEAD. Store output=op3. Physical address is 11.
- Three back-to-back loadd at offset 0 from RAM=5, ready_in=1 -> outputs 6, 7, 8; RAM=8.
- Load offset 9 with len=7 -> overflow_out=1, container_out=op3, no RAM change. A following add 2+3 -> 5 with overflow_out=0.
- Fetch-add op1=10 on RAM=0xFFFFFFFB -> output 0xFFFFFFFB, RAM=5 (wrap). With STATEFUL_ALU_SAT_EN defined: RAM=0xFFFFFFFF.
- ready_in held low 4 cycles in OUT -> container_out_valid stays high, RAM unchanged until the ready_in=1 cycle, ready_out high the cycle after.
- rst pulsed during EXEC of a store -> no write, ready_out=1, container_out_valid=0 the next cycle.
